// File: rtl/hog_lite_pkg.sv
// Shared register map, CTRL/STATUS bit positions and helpers for the HOG-lite
// Xillybus Lite register block.
package hog_lite_pkg;

  // Word index taken from user_addr[4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_THRESH  = 3'd2;
  localparam logic [2:0] REG_RESULT  = 3'd3;
  localparam logic [2:0] REG_PIX     = 3'd4;
  localparam logic [2:0] REG_SCRATCH = 3'd5;
  localparam logic [2:0] REG_VERSION = 3'd6;
  localparam logic [2:0] REG_PERF    = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_EMPTY   = 3;
  localparam int ST_OVF     = 4;
  localparam int ST_LVL_LSB = 8;

  localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/hog_lite_fifo.sv
// Synchronous first-word-fall-through pixel FIFO with occupancy level output.
// Flush has priority over push and pop; a push while full succeeds only alongside a pop.
module hog_lite_fifo #(
  parameter int FIFO_DEPTH = 16
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata,
  output logic                          valid,
  output logic                          full,
  output logic                          overflow_evt,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign valid        = (level != '0);
  assign full         = (level == LW'(FIFO_DEPTH));
  assign do_pop       = pop && valid && !flush;
  assign do_push      = push && (!full || do_pop) && !flush;
  assign overflow_evt = push && full && !do_pop && !flush;
  assign rdata        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage is data only; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hog_lite_regs.sv
// Xillybus Lite register block for the HOG/SVM engine: control, status, pixel FIFO.
// Optional busy-cycle counter on PERF when HOG_LITE_PERF_EN is defined.
module hog_lite_regs import hog_lite_pkg::*; #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] VERSION    = VERSION_DEFAULT
)(
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic        user_rden,
  input  logic [31:0] user_addr,
  input  logic [31:0] user_wr_data,
  output logic [31:0] user_rd_data,
  output logic        user_irq,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic [31:0] eng_score,
  output logic        pix_valid,
  output logic [31:0] pix_data,
  input  logic        pix_ready,
  output logic [31:0] thresh
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]    idx;
  logic          wr_ctrl, wr_status, start_ok, flush, pix_push, pix_pop;
  logic          irq_en, busy, done, overflow;
  logic [31:0]   result, scratch, perf_rd, status, rd_mux;
  logic          fifo_full, ovf_evt;
  logic [LW-1:0] level;
  logic [8:0]    level9;
  logic [7:0]    level8;
  logic          unused_addr;

  assign idx         = user_addr[4:2];
  assign unused_addr = ^{user_addr[31:5], user_addr[1:0]};

  assign wr_ctrl   = user_wren && (idx == REG_CTRL) && user_wstrb[0];
  assign wr_status = user_wren && (idx == REG_STATUS) && user_wstrb[0];
  assign start_ok  = wr_ctrl && user_wr_data[CTRL_START] && !busy;
  assign flush     = wr_ctrl && user_wr_data[CTRL_FLUSH];
  assign pix_push  = user_wren && (idx == REG_PIX) && (user_wstrb == 4'hF);
  assign pix_pop   = pix_valid && pix_ready;

  hog_lite_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (user_clk),
    .rst          (user_rst),
    .push         (pix_push),
    .pop          (pix_pop),
    .flush        (flush),
    .wdata        (user_wr_data),
    .rdata        (pix_data),
    .valid        (pix_valid),
    .full         (fifo_full),
    .overflow_evt (ovf_evt),
    .level        (level)
  );

  // Later assignments win: W1C clears precede sets, and a fresh start overrides eng_done.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      irq_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      result    <= '0;
      thresh    <= '0;
      scratch   <= '0;
      eng_start <= 1'b0;
      user_irq  <= 1'b0;
    end else begin
      eng_start <= start_ok;
      user_irq  <= eng_done && irq_en;
      if (wr_ctrl) irq_en <= user_wr_data[CTRL_IRQ_EN];
      if (user_wren && idx == REG_THRESH)
        thresh <= merge_lanes(thresh, user_wr_data, user_wstrb);
      if (user_wren && idx == REG_SCRATCH)
        scratch <= merge_lanes(scratch, user_wr_data, user_wstrb);
      if (wr_status && user_wr_data[ST_DONE]) done     <= 1'b0;
      if (wr_status && user_wr_data[ST_OVF])  overflow <= 1'b0;
      if (ovf_evt) overflow <= 1'b1;
      if (eng_done) begin
        busy   <= 1'b0;
        done   <= 1'b1;
        result <= eng_score;
      end
      if (start_ok) busy <= 1'b1;
    end
  end

`ifdef HOG_LITE_PERF_EN
  logic [31:0] perf;
  always_ff @(posedge user_clk) begin
    if (user_rst || start_ok)                perf <= '0;
    else if (busy && perf != 32'hFFFF_FFFF)  perf <= perf + 32'd1;
  end
  assign perf_rd = perf;
`else
  assign perf_rd = '0;
`endif

  // Level field is 8 bits wide; a 256-deep full FIFO reports 255 with FULL set.
  assign level9 = 9'(level);
  assign level8 = level9[8] ? 8'hFF : level9[7:0];

  always_comb begin
    status                     = '0;
    status[ST_BUSY]            = busy;
    status[ST_DONE]            = done;
    status[ST_FULL]            = fifo_full;
    status[ST_EMPTY]           = !pix_valid;
    status[ST_OVF]             = overflow;
    status[ST_LVL_LSB +: 8]    = level8;
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_CTRL:    rd_mux[CTRL_IRQ_EN] = irq_en;
      REG_STATUS:  rd_mux = status;
      REG_THRESH:  rd_mux = thresh;
      REG_RESULT:  rd_mux = result;
      REG_SCRATCH: rd_mux = scratch;
      REG_VERSION: rd_mux = VERSION;
      REG_PERF:    rd_mux = perf_rd;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst)       user_rd_data <= '0;
    else if (user_rden) user_rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_hog_lite_regs.sv
// Self-checking bench for hog_lite_regs: directed scenarios plus random traffic
// against a queue-based behavioural model of the register map.
module tb_hog_lite_regs;
  localparam int          DEPTH = 16;
  localparam logic [31:0] VER   = 32'h0001_0000;

  logic        user_clk = 1'b0;
  logic        user_rst, user_wren, user_rden, eng_done, pix_ready;
  logic [3:0]  user_wstrb;
  logic [31:0] user_addr, user_wr_data, eng_score;
  logic [31:0] user_rd_data, pix_data, thresh;
  logic        user_irq, eng_start, pix_valid;

  hog_lite_regs #(.FIFO_DEPTH(DEPTH), .VERSION(VER)) dut (
    .user_clk     (user_clk),
    .user_rst     (user_rst),
    .user_wren    (user_wren),
    .user_wstrb   (user_wstrb),
    .user_rden    (user_rden),
    .user_addr    (user_addr),
    .user_wr_data (user_wr_data),
    .user_rd_data (user_rd_data),
    .user_irq     (user_irq),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
    .eng_score    (eng_score),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .thresh       (thresh)
  );

  always #5 user_clk = ~user_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit          m_irq_en, m_busy, m_done, m_ovf;
  logic [31:0] m_thresh, m_scratch, m_result, m_perf;
  logic [31:0] m_q[$];
  logic [31:0] e_rd;
  bit          e_start, e_irq;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (cur & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] m_status();
    int lvl;
    lvl = m_q.size();
    return 32'((m_busy ? 1 : 0) + (m_done ? 2 : 0) + (lvl == DEPTH ? 4 : 0) +
               (lvl == 0 ? 8 : 0) + (m_ovf ? 16 : 0) + ((lvl > 255 ? 255 : lvl) * 256));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    logic [2:0] w;
    w = addr[4:2];
    case (w)
      3'd0: return m_irq_en ? 32'd2 : 32'd0;
      3'd1: return m_status();
      3'd2: return m_thresh;
      3'd3: return m_result;
      3'd5: return m_scratch;
      3'd6: return VER;
`ifdef HOG_LITE_PERF_EN
      3'd7: return m_perf;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic cyc(input bit rst, input bit wren, input logic [3:0] strb,
                     input logic [31:0] addr, input logic [31:0] wd, input bit rden,
                     input bit done, input logic [31:0] score, input bit ready);
    bit pop, push, flush, start, irq_old, busy_old;
    int sz;
    logic [2:0] w;
    user_rst = rst; user_wren = wren; user_wstrb = strb; user_addr = addr;
    user_wr_data = wd; user_rden = rden; eng_done = done; eng_score = score;
    pix_ready = ready;
    if (rst) begin
      m_irq_en = 0; m_busy = 0; m_done = 0; m_ovf = 0;
      m_thresh = 0; m_scratch = 0; m_result = 0; m_perf = 0;
      m_q.delete();
      e_rd = 0; e_start = 0; e_irq = 0;
    end else begin
      busy_old = m_busy; irq_old = m_irq_en; sz = m_q.size();
      if (rden) e_rd = m_read(addr);
      pop = ready && (sz > 0);
      start = 0; flush = 0; push = 0;
      w = addr[4:2];
      if (wren) begin
        case (w)
          3'd0: if (strb[0]) begin start = wd[0]; flush = wd[2]; m_irq_en = wd[1]; end
          3'd1: if (strb[0]) begin if (wd[1]) m_done = 0; if (wd[4]) m_ovf = 0; end
          3'd2: m_thresh = lanes(m_thresh, wd, strb);
          3'd4: push = (strb == 4'hF);
          3'd5: m_scratch = lanes(m_scratch, wd, strb);
          default: ;
        endcase
      end
      if (flush) m_q.delete();
      else begin
        if (push && sz == DEPTH && !pop) m_ovf = 1;
        if (pop) void'(m_q.pop_front());
        if (push && (sz < DEPTH || pop)) m_q.push_back(wd);
      end
      e_irq = done && irq_old;
      if (done) begin m_busy = 0; m_done = 1; m_result = score; end
      e_start = start && !busy_old;
      if (e_start) m_perf = 0;
      else if (busy_old && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
      if (e_start) m_busy = 1;
    end
    @(posedge user_clk);
    #1;
    check("rd_data", user_rd_data, e_rd);
    check("eng_start", 32'(eng_start), 32'(e_start));
    check("user_irq", 32'(user_irq), 32'(e_irq));
    check("thresh", thresh, m_thresh);
    check("pix_valid", 32'(pix_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("pix_data", pix_data, m_q[0]);
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb = 4'hF);
    cyc(0, 1, strb, addr, data, 0, 0, 32'h0, 0);
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(0, 0, 4'h0, addr, 32'h0, 1, 0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] pushed[$];
    logic [31:0] v, a, d;
    logic [3:0]  s;

    cyc(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    cyc(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    check("rst_rd", user_rd_data, 32'h0);
    check("rst_irq", 32'(user_irq), 32'd0);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_thresh", thresh, 32'h0);
    rd(32'h04); check("rst_status", user_rd_data, 32'h0000_0008);
    rd(32'h18); check("version", user_rd_data, 32'h0001_0000);

    // Byte-lane write to THRESH
    wr(32'h08, 32'hDEAD_BEEF, 4'b0101);
    rd(32'h08);
    check("thresh_lanes", user_rd_data, 32'h00AD_00EF);
    check("thresh_port", thresh, 32'h00AD_00EF);

    // Start with irq enabled, then completion
    wr(32'h00, 32'h3);
    check("start_pulse", 32'(eng_start), 32'd1);
    idle();
    check("start_once", 32'(eng_start), 32'd0);
    rd(32'h04); check("busy_status", user_rd_data, 32'h0000_0009);
    rd(32'h00); check("ctrl_selfclear", user_rd_data, 32'h0000_0002);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h1234_5678, 0);
    check("irq_pulse", 32'(user_irq), 32'd1);
    idle();
    check("irq_once", 32'(user_irq), 32'd0);
    rd(32'h0C); check("result", user_rd_data, 32'h1234_5678);
    rd(32'h04); check("done_status", user_rd_data, 32'h0000_000A);
    wr(32'h04, 32'h2);
    rd(32'h04); check("done_w1c", user_rd_data, 32'h0000_0008);

    // Read in the same cycle as a write returns the old value
    cyc(0, 1, 4'hF, 32'h14, 32'hCAFE_F00D, 1, 0, 32'h0, 0);
    check("rd_pre_write", user_rd_data, 32'h0);
    rd(32'h14); check("scratch", user_rd_data, 32'hCAFE_F00D);

    // Partial-strobe push is ignored; then overfill by one
    wr(32'h10, 32'h1111_1111, 4'h7);
    rd(32'h04); check("partial_push", user_rd_data, 32'h0000_0008);
    for (int i = 0; i < 17; i++) begin
      v = $urandom;
      pushed.push_back(v);
      wr(32'h10, v);
    end
    rd(32'h04); check("fifo_full_ovf", user_rd_data, 32'h0000_1014);
    for (int i = 0; i < 16; i++) begin
      check("fifo_order", pix_data, pushed[i]);
      cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
    end
    rd(32'h04); check("fifo_drained", user_rd_data, 32'h0000_0018);
    wr(32'h04, 32'h10);
    for (int i = 0; i < 16; i++) wr(32'h10, 32'(i));
    cyc(0, 1, 4'hF, 32'h10, 32'hA5A5_A5A5, 0, 0, 32'h0, 1);
    rd(32'h04); check("full_push_pop", user_rd_data, 32'h0000_1004);
    wr(32'h00, 32'h4);
    rd(32'h04); check("flush", user_rd_data, 32'h0000_0008);

    // Set beats W1C on done
    wr(32'h00, 32'h1);
    cyc(0, 1, 4'hF, 32'h04, 32'h2, 0, 1, 32'h0000_0055, 0);
    rd(32'h04); check("done_set_wins", user_rd_data & 32'h2, 32'h2);

    // Reset mid-run with queued pixels
    wr(32'h00, 32'h1);
    for (int i = 0; i < 5; i++) wr(32'h10, $urandom);
    cyc(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    check("mid_rst_rd", user_rd_data, 32'h0);
    check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_thresh", thresh, 32'h0);
    check("mid_rst_irq", 32'(user_irq), 32'd0);
    rd(32'h04); check("mid_rst_status", user_rd_data, 32'h0000_0008);
    wr(32'h00, 32'h1);
    check("restart", 32'(eng_start), 32'd1);

    // Busy-cycle counter over a 100-cycle run
    repeat (99) idle();
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0BAD_0BAD, 0);
    rd(32'h1C);
`ifdef HOG_LITE_PERF_EN
    check("perf", user_rd_data, 32'd100);
`else
    check("perf", user_rd_data, 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      a = $urandom;
      a[4:2] = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      d = $urandom;
      if (a[4:2] == 3'd0 && $urandom_range(0, 7) != 0) d[2] = 1'b0;
      s = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 1) == 1), s, a, d,
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0), $urandom,
          ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
